axi4_cmd_arbiter: RTL

Shares the single DDR AXI4 command port between `NUM_REQ` frame-buffer requesters, such as camera write, display read and detection-engine read channels. Requesters are served round-robin, one burst at a time. The block drives the shared address channel (`axi_atype` selects read/write) and watches the B and R handshakes to detect burst completion. A one-hot grant steers the external W/R data muxes to the owning requester for the whole burst.

---
 rtl/axi4_arb_pkg.sv | 18 +
 rtl/axi4_cmd_arbiter_rr_pick.sv | 37 +++
 rtl/axi4_cmd_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 command-port arbiter.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic C_ATYPE_RD = 1'b0;
  localparam logic C_ATYPE_WR = 1'b1;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo NUM_REQ. Returns a one-hot grant and its index.
module rr_pick
  import axi4_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan the requesters in rotated order and keep the first hit.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/axi4_cmd_arbiter.sv
// Round-robin sharing of one AXI4 address channel between NUM_REQ
// frame-buffer requesters, one burst outstanding at a time. Completion is
// detected from the B (write) or last R beat (read) handshake; a watchdog
// abandons bursts that never complete.
module axi4_cmd_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_type,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      axi_avalid,
  input  logic                      axi_aready,
  output logic                      axi_atype,
  output logic [ADDR_W-1:0]         axi_aaddr,
  output logic [7:0]                axi_alen,
  output logic [7:0]                axi_aid,
  input  logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic                      axi_rvalid,
  input  logic                      axi_rready,
  input  logic                      axi_rlast,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int                IDX_W    = idx_w(NUM_REQ);
  localparam int                WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [IDX_W-1:0]     gidx_q;
  logic [WD_W-1:0]      wdog_q;
  logic [WD_W-1:0]      wdog_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   req_done_q;
  logic                 avalid_q;
  logic                 atype_q;
  logic [ADDR_W-1:0]    aaddr_q;
  logic [7:0]           alen_q;
  logic [7:0]           aid_q;
  logic                 busy_q;
  logic                 timeout_err_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 cap_type;
  logic [ADDR_W-1:0]    cap_addr;
  logic [7:0]           cap_len;
  logic                 burst_cmpl;
  logic                 wd_expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Select the fields of the requester the picker chose.
  always_comb begin
    cap_type = C_ATYPE_RD;
    cap_addr = '0;
    cap_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        cap_type = req_type[i];
        cap_addr = req_addr[i*ADDR_W +: ADDR_W];
        cap_len  = req_len[i*8 +: 8];
      end
    end
  end

  // Burst completion, saturating watchdog step and next round-robin pointer.
  always_comb begin
    if (atype_q == C_ATYPE_WR) burst_cmpl = axi_bvalid & axi_bready;
    else                       burst_cmpl = axi_rvalid & axi_rready & axi_rlast;
    wdog_d    = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WD_W'(1);
    wd_expire = (wdog_d == WD_MAX);
    rr_ptr_d  = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
  end

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      gidx_q        <= '0;
      wdog_q        <= '0;
      grant_q       <= '0;
      req_ready_q   <= '0;
      req_done_q    <= '0;
      avalid_q      <= 1'b0;
      atype_q       <= C_ATYPE_RD;
      aaddr_q       <= '0;
      alen_q        <= '0;
      aid_q         <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      req_done_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            state_q  <= S_ADDR;
            busy_q   <= 1'b1;
            grant_q  <= pick_gnt;
            gidx_q   <= pick_idx;
            avalid_q <= 1'b1;
            atype_q  <= cap_type;
            aaddr_q  <= cap_addr;
            alen_q   <= cap_len;
            aid_q    <= {{(8-IDX_W){1'b0}}, pick_idx};
          end
        end
        S_ADDR: begin
          if (axi_aready) begin
            state_q     <= S_WAIT;
            avalid_q    <= 1'b0;
            req_ready_q <= grant_q;
            wdog_q      <= '0;
          end
        end
        S_WAIT: begin
          wdog_q <= wdog_d;
          // A completion on the expiry cycle still counts as a clean finish.
          if (burst_cmpl || wd_expire) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            req_done_q <= grant_q;
            grant_q    <= '0;
            rr_ptr_q   <= rr_ptr_d;
            if (!burst_cmpl) timeout_err_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          grant_q  <= '0;
          avalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign req_done    = req_done_q;
  assign grant       = grant_q;
  assign axi_avalid  = avalid_q;
  assign axi_atype   = atype_q;
  assign axi_aaddr   = aaddr_q;
  assign axi_alen    = alen_q;
  assign axi_aid     = aid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
